// File: rtl/mean_square_accumulator.sv
// Mean-square stage: squares a signed sample stream and emits the mean of
// every 2**LOG2_N squares over a valid/ready handshake.
module mean_square_accumulator #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 2,
  parameter int ROUND  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*DATA_W-1:0]   ms_data,
  output logic                  ms_valid,
  input  logic                  ms_ready
);

  localparam int SQ_W  = 2 * DATA_W;
  localparam int ACC_W = SQ_W + LOG2_N;
  localparam logic [ACC_W-1:0]  ONE_ACC = ACC_W'(1);
  localparam logic [ACC_W-1:0]  RND     = (ROUND != 0) ? (ONE_ACC << (LOG2_N - 1)) : ACC_W'(0);
  localparam logic [LOG2_N-1:0] LAST    = {LOG2_N{1'b1}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state_r, next_state_s;
  logic [LOG2_N-1:0]    count_r;
  logic [ACC_W-1:0]     acc_r;
  logic [SQ_W-1:0]      sq_r;
  logic                 in_ready_r;
  logic [SQ_W-1:0]      ms_data_r;
  logic                 ms_valid_r;

  logic                 accept_s;
  logic signed [SQ_W-1:0] in_ext_s;
  logic signed [SQ_W-1:0] prod_s;
  logic [ACC_W-1:0]     sum_s;
  logic [SQ_W-1:0]      mean_s;

  assign in_ready = in_ready_r;
  assign ms_data  = ms_data_r;
  assign ms_valid = ms_valid_r;

  // Datapath: square of the incoming sample and the rounded window mean.
  always_comb begin
    accept_s = in_valid & in_ready_r & ~clear;
    in_ext_s = SQ_W'($signed(in_data));
    prod_s   = in_ext_s * in_ext_s;
    // The last square is still in sq_r during DRAIN, so fold it in here.
    sum_s    = acc_r + ACC_W'(sq_r) + RND;
    mean_s   = SQ_W'(sum_s >> LOG2_N);
  end

  // Next-state decode for the window FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ACCUM: begin
        if (accept_s && (count_r == LAST)) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = ACCUM;
        end
      end
      DRAIN: begin
        next_state_s = HOLD;
      end
      HOLD: begin
        if (ms_ready) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = ACCUM;
      end
    endcase
  end

  // State, counters, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ACCUM;
      in_ready_r <= 1'b1;
      count_r    <= LOG2_N'(0);
      acc_r      <= ACC_W'(0);
      sq_r       <= SQ_W'(0);
      ms_data_r  <= SQ_W'(0);
      ms_valid_r <= 1'b0;
    end else if (clear) begin
      state_r    <= ACCUM;
      in_ready_r <= 1'b1;
      count_r    <= LOG2_N'(0);
      acc_r      <= ACC_W'(0);
      sq_r       <= SQ_W'(0);
      ms_data_r  <= SQ_W'(0);
      ms_valid_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= (next_state_s == ACCUM);

      if (accept_s) begin
        sq_r <= $unsigned(prod_s);
        if (count_r == LAST) begin
          count_r <= LOG2_N'(0);
        end else begin
          count_r <= count_r + LOG2_N'(1);
        end
      end else begin
        sq_r <= SQ_W'(0);
      end

      if (state_r == DRAIN) begin
        acc_r      <= ACC_W'(0);
        ms_data_r  <= mean_s;
        ms_valid_r <= 1'b1;
      end else begin
        acc_r <= acc_r + ACC_W'(sq_r);
        if ((state_r == HOLD) && ms_ready) begin
          ms_valid_r <= 1'b0;
        end else begin
          ms_valid_r <= ms_valid_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_mean_square_accumulator.sv
// Bench: drives a truncating and a rounding instance with identical windows
// and compares both against table constants and an arithmetic model.
module tb_mean_square_accumulator;

  localparam int DATA_W = 8;
  localparam int LOG2_N = 2;
  localparam int N      = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clear;
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                ms_ready;
  logic                in_ready0, in_ready1;
  logic [2*DATA_W-1:0] ms_data0, ms_data1;
  logic                ms_valid0, ms_valid1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mean_square_accumulator #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .ROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .ms_data(ms_data0), .ms_valid(ms_valid0), .ms_ready(ms_ready));

  mean_square_accumulator #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .ROUND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .ms_data(ms_data1), .ms_valid(ms_valid1), .ms_ready(ms_ready));

  typedef logic [N-1:0][DATA_W-1:0] win_t;

  typedef struct packed {
    win_t        s;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  function automatic win_t mk(input int a, input int b, input int c, input int d);
    win_t w;
    w[0] = DATA_W'(a);
    w[1] = DATA_W'(b);
    w[2] = DATA_W'(c);
    w[3] = DATA_W'(d);
    return w;
  endfunction

  // Reference: integer mean of squares, optionally rounded half up.
  function automatic int ms_model(input win_t w, input int rnd);
    int sum;
    int v;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      v = $signed(w[i]);
      sum += v * v;
    end
    if (rnd != 0) sum += N / 2;
    return sum / N;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts and ends on a negedge in ACCUM; hold = extra cycles of ms_ready low.
  task automatic run_window(input win_t w, input int e0, input int e1, input int hold);
    ms_ready = (hold == 0);
    for (int i = 0; i < N; i++) begin
      chk("in_ready0 accum", int'(in_ready0), 1);
      chk("in_ready1 accum", int'(in_ready1), 1);
      in_data  = w[i];
      in_valid = 1'b1;
      @(negedge clk);
    end
    chk("drain ms_valid0", int'(ms_valid0), 0);
    chk("drain in_ready0", int'(in_ready0), 0);
    chk("drain in_ready1", int'(in_ready1), 0);
    in_data = 8'd99;
    @(negedge clk);
    chk("hold ms_valid0", int'(ms_valid0), 1);
    chk("hold ms_valid1", int'(ms_valid1), 1);
    chk("ms_data trunc", int'(ms_data0), e0);
    chk("ms_data round", int'(ms_data1), e1);
    chk("hold in_ready0", int'(in_ready0), 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid;
      in_data  = DATA_W'($urandom);
      @(negedge clk);
      chk("stall ms_valid0", int'(ms_valid0), 1);
      chk("stall ms_data0", int'(ms_data0), e0);
      chk("stall ms_data1", int'(ms_data1), e1);
      chk("stall in_ready1", int'(in_ready1), 0);
    end
    ms_ready = 1'b1;
    @(negedge clk);
    chk("post ms_valid0", int'(ms_valid0), 0);
    chk("post ms_valid1", int'(ms_valid1), 0);
  endtask

  vec_t tbl [7];

  initial begin
    win_t w;
    tbl[0] = '{s: mk(3, -4, 5, -6),         e0: 16'd21,    e1: 16'd22};
    tbl[1] = '{s: mk(1, 1, 1, 2),           e0: 16'd1,     e1: 16'd2};
    tbl[2] = '{s: mk(-128, -128, -128, -128), e0: 16'd16384, e1: 16'd16384};
    tbl[3] = '{s: mk(127, 127, 127, 127),   e0: 16'd16129, e1: 16'd16129};
    tbl[4] = '{s: mk(1, 2, 3, 4),           e0: 16'd7,     e1: 16'd8};
    tbl[5] = '{s: mk(0, 0, 0, 0),           e0: 16'd0,     e1: 16'd0};
    tbl[6] = '{s: mk(-1, -1, -1, -1),       e0: 16'd1,     e1: 16'd1};

    rst_n    = 1'b0;
    clear    = 1'b0;
    in_data  = 8'd0;
    in_valid = 1'b0;
    ms_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset in_ready", int'(in_ready0), 1);
    chk("reset ms_valid", int'(ms_valid1), 0);
    chk("reset ms_data", int'(ms_data0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_window(tbl[i].s, int'(tbl[i].e0), int'(tbl[i].e1), 0);
    end
    run_window(tbl[0].s, 21, 22, 5);

    // Clear mid-window; the sample presented with clear must not count.
    in_data  = 8'd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'd10;
    @(negedge clk);
    clear   = 1'b1;
    in_data = 8'd50;
    @(negedge clk);
    clear = 1'b0;
    run_window(mk(2, 2, 2, 2), 4, 4, 0);

    // Asynchronous reset while a result is waiting in HOLD.
    ms_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_data  = 8'd100;
      in_valid = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("pre-reset ms_valid", int'(ms_valid0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async ms_valid0", int'(ms_valid0), 0);
    chk("async ms_valid1", int'(ms_valid1), 0);
    chk("async in_ready", int'(in_ready0), 1);
    chk("async ms_data", int'(ms_data1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_window(tbl[4].s, 7, 8, 0);

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < N; i++) w[i] = DATA_W'($urandom);
      run_window(w, ms_model(w, 0), ms_model(w, 1), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mean_square_accumulator.md
Name: mean_square_accumulator

Overview:
Upstream feeder for the square-root stage in the RMS path. It accepts a stream of signed samples and squares each one. It accumulates 2**LOG2_N squares per window and emits their mean (the mean square) as an unsigned value. The downstream square-root stage consumes that value to form the RMS. Both ports use valid/ready handshakes.

Parameters:
DATA_W, 8, signed input sample width (>=2)
LOG2_N, 2, log2 of window length; N = 2**LOG2_N samples per window (1..8)
ROUND, 0, 0 = truncate the divide-by-N; 1 = round half up (add 2**(LOG2_N-1) before the shift)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous discard of the partial window, priority over all other inputs
in_data  in  DATA_W  signed two's-complement sample
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
ms_data  out  2*DATA_W  unsigned mean square, to the square-root stage
ms_valid  out  1  ms_data valid
ms_ready  in  1  downstream accepts ms_data

Behaviour:
- Reset (async assert, sync release) sets: state=ACCUM, in_ready=1, ms_valid=0, ms_data=0, accumulator=0, sample count=0, square register=0.
- Accumulator width is 2*DATA_W+LOG2_N unsigned, so it can never overflow. The maximum square is (-2**(DATA_W-1))**2 = 2**(2*DATA_W-2), so the mean always fits in 2*DATA_W bits.
- Pipeline: a sample accepted at edge k has its square registered at edge k. The square is added to the accumulator at edge k+1.
- FSM states:
  - ACCUM: in_ready=1. On in_valid&in_ready, the count increments. When the accepted sample is the Nth, go to DRAIN and reset the count to 0.
  - DRAIN: lasts one cycle, in_ready=0. At the next edge: ms_data = (acc + sq + (ROUND ? 2**(LOG2_N-1) : 0)) >> LOG2_N; ms_valid=1; accumulator=0; go to HOLD.
  - HOLD: in_ready=0. ms_data and ms_valid are held stable until ms_valid&ms_ready. On that handshake: ms_valid=0, go to ACCUM.
- Latency: ms_valid rises one edge after the edge that accepts the last sample of a window.
- Throughput with ms_ready tied high: one window per N+2 cycles.
- in_ready is a registered/state-decoded output, never combinationally dependent on in_valid or ms_ready.
- ROUND=1 saturation: the rounded sum cannot exceed the accumulator width, and the result stays within 2*DATA_W bits.
- clear=1, in any state: accumulator, count and square register go to 0, ms_valid=0, state=ACCUM.
  - A pending ms_data is dropped.
  - A sample presented in the same cycle as clear is not accepted, and in_ready is treated as 0 for that cycle.
- in_valid while in_ready=0: the sample is ignored, and the producer holds it per the handshake.
- rst_n asserted mid-window or in HOLD: the window is lost and all outputs return to their reset values immediately (asynchronously).
- N=2 (LOG2_N=1): the same FSM applies. The count wraps at 2.

Test Plan:
- DATA_W=8, LOG2_N=2, ROUND=0; samples 3,-4,5,-6 back-to-back, ms_ready=1 -> ms_data=21 (86>>2), ms_valid high exactly one cycle after the 4th accept, in_ready low for DRAIN and HOLD.
- Same samples with ROUND=1 -> ms_data=22. Then samples 1,1,1,2 (sum 7) -> ROUND=1 gives 2, ROUND=0 gives 1.
- Four samples of -128 -> ms_data=16384, no overflow. Four samples of 127 -> 16129.
- ms_ready held low 5 cycles after ms_valid rises -> ms_data stable, ms_valid stays 1, in_ready stays 0, in_valid pulses ignored. ms_ready=1 -> handshake, in_ready=1 next cycle.
- Continuous in_valid, ms_ready=1, three windows (1,2,3,4 / 0,0,0,0 / -1,-1,-1,-1) -> ms_data 7, 0, 1. Windows spaced N+2=6 cycles apart, no sample lost or duplicated.
- clear after 2 samples of a window, then 4 samples of 2 -> ms_data=4. rst_n pulsed low during HOLD -> ms_valid=0 and in_ready=1 immediately, next window computed from fresh samples only.
